// File: rtl/mos6502_pkg.sv
// Shared 6502 constants: interrupt/reset vectors and default bus widths.
package mos6502_pkg;
  localparam int          DEF_DATA_W = 8;
  localparam int          DEF_ADDR_W = 16;
  localparam logic [15:0] RESET_VEC  = 16'hFFFC;
  localparam logic [15:0] NMI_VEC    = 16'hFFFA;
  localparam logic [15:0] IRQ_VEC    = 16'hFFFE;
endpackage

// File: rtl/mos6502_fetchq_ram.sv
// Fetch-queue storage: one write port, async read of head entry and, with
// MOS6502_FETCHQ_PEEK_EN defined, of the entry after the head.
module mos6502_fetchq_ram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] head_addr,
  output logic [WIDTH-1:0]         head_data
`ifdef MOS6502_FETCHQ_PEEK_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] next_addr,
  output logic [WIDTH-1:0]         next_data
`endif
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign head_data = mem[head_addr];
`ifdef MOS6502_FETCHQ_PEEK_EN
  assign next_data = mem[next_addr];
`endif

endmodule

// File: rtl/mos6502_fetch_queue.sv
// 6502 instruction prefetch queue with redirect flush.
// Optional peek-at-second-entry port enabled by MOS6502_FETCHQ_PEEK_EN.
module mos6502_fetch_queue
  import mos6502_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_VEC)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rdy,
  output logic [ADDR_W-1:0]          add_bus,
  output logic                       fetch_en,
  input  logic [DATA_W-1:0]          d_in,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [DATA_W-1:0]          deq_data,
  output logic [ADDR_W-1:0]          deq_addr,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef MOS6502_FETCHQ_PEEK_EN
  ,
  output logic                       peek_valid,
  output logic [DATA_W-1:0]          peek_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DATA_W + ADDR_W;

  logic [PTR_W-1:0] head, tail;
  logic [ENT_W-1:0] head_word;
  logic             enq, deq, not_empty;

  assign not_empty = (count != '0);
  assign fetch_en  = reset && (count < CNT_W'(DEPTH)) && !redirect;
  assign deq_valid = not_empty && !redirect;
  assign enq       = fetch_en && rdy;
  assign deq       = deq_valid && deq_ready;

  // Storage is uninitialised, so the head is masked to zero while empty.
  assign deq_data = not_empty ? head_word[ENT_W-1:ADDR_W] : '0;
  assign deq_addr = not_empty ? head_word[ADDR_W-1:0]     : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      add_bus <= RESET_ADDR;
      count   <= '0;
      head    <= '0;
      tail    <= '0;
    end else if (redirect) begin
      add_bus <= redirect_addr;
      count   <= '0;
      head    <= '0;
      tail    <= '0;
    end else begin
      if (enq) begin
        tail    <= tail + PTR_W'(1);
        add_bus <= add_bus + ADDR_W'(1);
      end
      if (deq) head <= head + PTR_W'(1);
      if (enq && !deq)      count <= count + CNT_W'(1);
      else if (deq && !enq) count <= count - CNT_W'(1);
    end
  end

`ifdef MOS6502_FETCHQ_PEEK_EN
  logic [ENT_W-1:0] next_word;
  logic             two_plus;

  assign two_plus   = (count >= CNT_W'(2));
  assign peek_valid = two_plus && !redirect;
  assign peek_data  = two_plus ? next_word[ENT_W-1:ADDR_W] : '0;
`endif

  mos6502_fetchq_ram #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .we        (enq),
    .waddr     (tail),
    .wdata     ({d_in, add_bus}),
    .head_addr (head),
    .head_data (head_word)
`ifdef MOS6502_FETCHQ_PEEK_EN
    ,
    .next_addr (head + PTR_W'(1)),
    .next_data (next_word)
`endif
  );

endmodule

// File: doc/mos6502_fetch_queue.md
MOS6502_FETCH_QUEUE -- requirements
Module: mos6502_fetch_queue

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the fetched word width.
REQ-002 Parameter ADDR_W, default 16, SHALL set the fetch address width.
REQ-003 Parameter DEPTH, default 4, SHALL set queue entries; legal values are powers of two, at least 2.
REQ-004 Parameter RESET_ADDR, default 16'hFFFC, SHALL set the first fetch address after reset.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  in  1  SHALL be synchronous, active-low reset.
REQ-007 rdy  in  1  memory ready; 0 stalls fetch.
REQ-008 add_bus  out  ADDR_W  current fetch address.
REQ-009 fetch_en  out  1  read strobe; high when a fetch is requested this cycle.
REQ-010 d_in  in  DATA_W  read data for add_bus, valid in the same cycle as fetch_en and rdy.
REQ-011 redirect  in  1  flush the queue and restart fetch.
REQ-012 redirect_addr  in  ADDR_W  new fetch address.
REQ-013 deq_valid  out  1  head entry available.
REQ-014 deq_ready  in  1  consumer takes the head entry.
REQ-015 deq_data  out  DATA_W  head entry data.
REQ-016 deq_addr  out  ADDR_W  address the head entry was fetched from.
REQ-017 count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-018 fetch_en SHALL be high iff reset is high, count is less than DEPTH, and redirect is low.
REQ-019 Enqueue SHALL occur on an edge where fetch_en and rdy are both 1: {d_in, add_bus} is written at the tail, and add_bus increments by 1 modulo 2^ADDR_W (FFFF wraps to 0000).
REQ-020 With rdy=0, add_bus, the tail and count SHALL hold; dequeue is unaffected by rdy.
REQ-021 Dequeue SHALL occur on an edge where deq_valid and deq_ready are both 1; the head advances by 1.
REQ-022 deq_valid SHALL equal (count != 0) and not redirect.
REQ-023 Latency: a word enqueued at edge N SHALL present as deq_valid after edge N; there is no combinational d_in-to-deq_data bypass.
REQ-024 Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-025 When full (count == DEPTH), fetch_en SHALL be 0; a dequeue in that cycle makes room for the next cycle.
REQ-026 Head and tail pointers SHALL be log2(DEPTH) bits and wrap naturally.
REQ-027 Redirect takes priority over everything. On an edge with redirect=1:
- count SHALL be set to 0 and both pointers to 0;
- add_bus SHALL load redirect_addr;
- any concurrent enqueue or dequeue is discarded.
REQ-028 The first fetch from redirect_addr SHALL be issued in the cycle after redirect.
REQ-029 Redirect held high for multiple cycles SHALL keep the queue empty and reload add_bus each cycle.

Reset
REQ-030 On an edge with reset=0, the block SHALL set: add_bus=RESET_ADDR, count=0, pointers=0, deq_valid=0, fetch_en=0, deq_data=0, deq_addr=0.
REQ-031 Reset mid-fetch SHALL discard all queued entries.
REQ-032 The first fetch SHALL be issued in the first cycle with reset=1.

Configuration
REQ-033 With MOS6502_FETCHQ_PEEK_EN defined, the block SHALL add these ports, for two-byte operand decode:
- peek_valid  out  1  high when count >= 2 and redirect = 0;
- peek_data  out  DATA_W  the entry after the head.
REQ-034 Without MOS6502_FETCHQ_PEEK_EN, those ports and their logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-035 Shared package mos6502_pkg SHALL hold:
- the reset/NMI/IRQ vector constants (FFFC, FFFA, FFFE);
- default DATA_W and ADDR_W.
REQ-036 Storage SHALL be the sub-module mos6502_fetchq_ram: DEPTH x (DATA_W+ADDR_W), one write port, two async read ports (head, head+1).
REQ-037 Pointers, count and add_bus SHALL live in the top module.

Verification
REQ-038 Reset then rdy=1 with deq_ready=0 -> add_bus runs FFFC, FFFD, FFFE, FFFF; count=4; fetch_en=0 while full.
REQ-039 rdy toggled 1,0,1,0 with deq_ready=1 -> exactly one enqueue per rdy=1 cycle; deq_addr sequence is contiguous with no duplicates.
REQ-040 Queue full, deq_ready=1 one cycle -> count goes 4->3, then back to 4 next cycle; deq_data order is preserved.
REQ-041 redirect=1 with redirect_addr=0x0600, same cycle as enqueue+dequeue -> next cycle count=0, deq_valid=0, add_bus=0x0600; the following cycle fetch_en=1.
REQ-042 Redirect to FFFE, free-running -> add_bus FFFE, FFFF, 0000; deq_addr matches each address.
REQ-043 PEEK build, entries A9 then 05 queued -> peek_valid=1, peek_data=05; after one dequeue, peek_valid=0.
